// File: rtl/inst_prefetch_if.sv
// Bus bundle for the instruction prefetcher: ROM read port plus the core-facing
// valid/ready instruction stream and occupancy.
interface inst_prefetch_if #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
);
  logic                     rom_ren_o;
  logic [AW-1:0]            rom_addr_o;
  logic [DW-1:0]            rom_data_i;
  logic                     inst_valid_o;
  logic [DW-1:0]            inst_o;
  logic [AW-1:0]            inst_pc_o;
  logic                     inst_ready_i;
  logic [$clog2(DEPTH):0]   fifo_cnt_o;

  modport master (
    output rom_ren_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, fifo_cnt_o,
    input  rom_data_i, inst_ready_i
  );

  modport slave (
    input  rom_ren_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o, fifo_cnt_o,
    output rom_data_i, inst_ready_i
  );
endinterface

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: issues ROM reads (1-cycle latency) and
// buffers {pc, inst} pairs in a small FIFO for the core fetch stage.
module inst_prefetch #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [AW-1:0]   flush_pc_i,
  input  logic            halt_i,
  inst_prefetch_if.master bus
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] fifo_pc_q   [DEPTH];
  logic [DW-1:0] fifo_inst_q [DEPTH];

  logic          issue, push, pop, head_vld;
  logic [CW:0]   occupancy;
  logic          unused_flush_lsb;

  // Redirect targets are word aligned, so the low address bits are ignored.
  assign unused_flush_lsb = ^flush_pc_i[1:0];

  always_comb begin
    // Reserve a slot for the read in flight so a capture can never overflow.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue     = !rst && !halt_i && !flush_i && (occupancy < DEPTH_C);
    head_vld  = !rst && (count_q != '0);
    push      = !rst && !flush_i && inflight_q;
    pop       = head_vld && bus.inst_ready_i;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(pop);

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + AW'(4);
      inflight_pc_d = fetch_pc_q;
    end

    if (flush_i) begin
      fetch_pc_d = {flush_pc_i[AW-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.rom_data_i;
    end
  end

  assign bus.rom_ren_o    = issue;
  assign bus.rom_addr_o   = rst ? RESET_PC : fetch_pc_q;
  assign bus.inst_valid_o = head_vld;
  assign bus.inst_o       = head_vld ? fifo_inst_q[rd_ptr_q] : '0;
  assign bus.inst_pc_o    = head_vld ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.fifo_cnt_o   = rst ? '0 : count_q;
endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_inst_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] flush_pc = '0;

  int n_tests = 0;
  int n_fail  = 0;

  inst_prefetch_if #(.DW(32), .AW(32), .DEPTH(DEPTH)) bus0 ();
  inst_prefetch_if #(.DW(32), .AW(32), .DEPTH(DEPTH)) bus1 ();

  inst_prefetch #(.DW(32), .AW(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .flush_pc_i(flush_pc), .halt_i(halt), .bus(bus0));
  inst_prefetch #(.DW(32), .AW(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .flush_pc_i(flush_pc), .halt_i(halt), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign bus0.inst_ready_i = ready;
  assign bus1.inst_ready_i = ready;

  always @(posedge clk) begin
    if (bus0.rom_ren_o) bus0.rom_data_i <= rom_word(bus0.rom_addr_o);
    if (bus1.rom_ren_o) bus1.rom_data_i <= rom_word(bus1.rom_addr_o);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: the buffer is a queue of {pc, inst}; one pending read.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc = '0;
  logic [31:0] m_ipc = '0;
  bit          m_infl = 1'b0;
  bit          m_init = 1'b0;
  bit          m_pop, m_iss;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_fpc  = 32'h0;
      m_infl = 1'b0;
      m_init = 1'b1;
    end else begin
      m_pop = (mq.size() != 0) && ready;
      m_iss = !halt && !flush && (mq.size() + int'(m_infl) < DEPTH);
      if (flush) begin
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = {flush_pc[31:2], 2'b00};
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_infl) mq.push_back('{pc: m_ipc, inst: rom_word(m_ipc)});
        if (m_iss) begin
          m_ipc = m_fpc;
          m_fpc = m_fpc + 32'd4;
        end
        m_infl = m_iss;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_ren", 64'(bus0.rom_ren_o),
          64'(!rst && !halt && !flush && (mq.size() + int'(m_infl) < DEPTH)));
      chk("m_addr", 64'(bus0.rom_addr_o), rst ? 64'h0 : 64'(m_fpc));
      chk("m_valid", 64'(bus0.inst_valid_o), 64'(!rst && mq.size() != 0));
      chk("m_cnt", 64'(bus0.fifo_cnt_o), rst ? 64'h0 : 64'(mq.size()));
      if (!rst && mq.size() != 0) begin
        chk("m_pc", 64'(bus0.inst_pc_o), 64'(mq[0].pc));
        chk("m_inst", 64'(bus0.inst_o), 64'(mq[0].inst));
      end
    end
  end

  ent_t acc0[$];
  ent_t acc1[$];
  always @(negedge clk) begin
    if (bus0.inst_valid_o && ready) acc0.push_back('{pc: bus0.inst_pc_o, inst: bus0.inst_o});
    if (bus1.inst_valid_o && ready) acc1.push_back('{pc: bus1.inst_pc_o, inst: bus1.inst_o});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin cyc(); smp(); end
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          ren;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    int          cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit r, input bit rd, input bit en, input logic [31:0] a,
                      input bit v, input logic [31:0] p, input int c);
    vec_t e;
    e.rst = r; e.rdy = rd; e.ren = en; e.addr = a; e.vld = v; e.pc = p; e.cnt = c;
    tbl.push_back(e);
  endtask

  initial begin
    // Streaming start-up, then a reset and a fill with the core stalled.
    addv(1, 1, 0, 32'h00, 0, 32'h00, 0);
    addv(0, 1, 1, 32'h00, 0, 32'h00, 0);
    addv(0, 1, 1, 32'h04, 0, 32'h00, 0);
    addv(0, 1, 1, 32'h08, 1, 32'h00, 1);
    addv(0, 1, 1, 32'h0C, 1, 32'h04, 1);
    addv(0, 1, 1, 32'h10, 1, 32'h08, 1);
    addv(1, 0, 0, 32'h00, 0, 32'h00, 0);
    addv(0, 0, 1, 32'h00, 0, 32'h00, 0);
    addv(0, 0, 1, 32'h04, 0, 32'h00, 0);
    addv(0, 0, 1, 32'h08, 1, 32'h00, 1);
    addv(0, 0, 1, 32'h0C, 1, 32'h00, 2);
    addv(0, 0, 0, 32'h10, 1, 32'h00, 3);
    addv(0, 0, 0, 32'h10, 1, 32'h00, 4);
    addv(0, 0, 0, 32'h10, 1, 32'h00, 4);
    addv(0, 1, 0, 32'h10, 1, 32'h00, 4);
    addv(0, 1, 1, 32'h10, 1, 32'h04, 3);
    addv(0, 1, 1, 32'h14, 1, 32'h08, 2);
    addv(0, 1, 1, 32'h18, 1, 32'h0C, 2);
    addv(0, 1, 1, 32'h1C, 1, 32'h10, 2);

    foreach (tbl[i]) begin
      cyc();
      rst = tbl[i].rst; ready = tbl[i].rdy; halt = 1'b0; flush = 1'b0;
      smp();
      chk($sformatf("tbl%0d_ren", i), 64'(bus0.rom_ren_o), 64'(tbl[i].ren));
      chk($sformatf("tbl%0d_addr", i), 64'(bus0.rom_addr_o), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_vld", i), 64'(bus0.inst_valid_o), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_cnt", i), 64'(bus0.fifo_cnt_o), 64'(tbl[i].cnt));
      if (tbl[i].vld || tbl[i].rst) begin
        chk($sformatf("tbl%0d_pc", i), 64'(bus0.inst_pc_o), 64'(tbl[i].pc));
        chk($sformatf("tbl%0d_inst", i), 64'(bus0.inst_o),
            tbl[i].rst ? 64'h0 : 64'(rom_word(tbl[i].pc)));
      end
    end

    // Flush with three entries buffered and one read in flight.
    cyc(); rst = 1'b1; ready = 1'b0; smp();
    cyc(); rst = 1'b0; smp();
    run(3);
    cyc(); flush = 1'b1; flush_pc = 32'h0000_0103; smp();
    chk("flush_pre_cnt", 64'(bus0.fifo_cnt_o), 64'd3);
    cyc(); flush = 1'b0; ready = 1'b1; smp();
    chk("flush_cnt", 64'(bus0.fifo_cnt_o), 64'd0);
    chk("flush_vld", 64'(bus0.inst_valid_o), 64'd0);
    chk("flush_addr", 64'(bus0.rom_addr_o), 64'h100);
    chk("flush_ren", 64'(bus0.rom_ren_o), 64'd1);
    for (int k = 0; k < 8 && !bus0.inst_valid_o; k++) begin cyc(); smp(); end
    chk("flush_wait_vld", 64'(bus0.inst_valid_o), 64'd1);
    chk("flush_first_pc", 64'(bus0.inst_pc_o), 64'h100);
    chk("flush_first_inst", 64'(bus0.inst_o), 64'h1000_0040);

    // Halt in steady state: drains, then resumes without gaps.
    cyc(); rst = 1'b1; ready = 1'b1; smp();
    cyc(); rst = 1'b0; smp();
    run(6);
    acc0.delete();
    for (int k = 0; k < 10; k++) begin
      cyc(); halt = 1'b1; smp();
      chk("halt_ren", 64'(bus0.rom_ren_o), 64'd0);
    end
    chk("halt_drain_cnt", 64'(bus0.fifo_cnt_o), 64'd0);
    chk("halt_drain_vld", 64'(bus0.inst_valid_o), 64'd0);
    cyc(); halt = 1'b0; smp();
    run(7);
    chk("halt_acc_n", 64'(acc0.size() >= 6), 64'd1);
    for (int i = 1; i < acc0.size(); i++)
      chk("halt_contig", 64'(acc0[i].pc), 64'(acc0[i-1].pc + 32'd4));

    // Address wrap from a reset PC near the top of the space.
    cyc(); rst = 1'b1; ready = 1'b1; smp();
    acc1.delete();
    cyc(); rst = 1'b0; smp();
    run(6);
    chk("wrap_n", 64'(acc1.size() >= 3), 64'd1);
    if (acc1.size() >= 3) begin
      chk("wrap_pc0", 64'(acc1[0].pc), 64'hFFFF_FFF8);
      chk("wrap_pc1", 64'(acc1[1].pc), 64'hFFFF_FFFC);
      chk("wrap_pc2", 64'(acc1[2].pc), 64'h0000_0000);
      chk("wrap_inst0", 64'(acc1[0].inst), 64'h4FFF_FFFE);
      chk("wrap_inst2", 64'(acc1[2].inst), 64'h1000_0000);
    end

    // Reset mid-stream with two entries buffered.
    cyc(); rst = 1'b1; ready = 1'b0; smp();
    cyc(); rst = 1'b0; smp();
    run(3);
    chk("rst_pre_cnt", 64'(bus0.fifo_cnt_o), 64'd2);
    cyc(); rst = 1'b1; smp();
    chk("rst_ren", 64'(bus0.rom_ren_o), 64'd0);
    chk("rst_vld", 64'(bus0.inst_valid_o), 64'd0);
    chk("rst_inst", 64'(bus0.inst_o), 64'd0);
    chk("rst_pc", 64'(bus0.inst_pc_o), 64'd0);
    chk("rst_cnt", 64'(bus0.fifo_cnt_o), 64'd0);
    cyc(); rst = 1'b0; ready = 1'b1; smp();
    chk("rst_r0_cnt", 64'(bus0.fifo_cnt_o), 64'd0);
    chk("rst_r0_vld", 64'(bus0.inst_valid_o), 64'd0);
    cyc(); smp();
    chk("rst_r1_vld", 64'(bus0.inst_valid_o), 64'd0);
    cyc(); smp();
    chk("rst_r2_vld", 64'(bus0.inst_valid_o), 64'd1);
    chk("rst_r2_pc", 64'(bus0.inst_pc_o), 64'd0);
    chk("rst_r2_inst", 64'(bus0.inst_o), 64'h1000_0000);

    // Randomized traffic; the reference model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      flush_pc = $urandom;
      if ($urandom_range(0, 19) == 0) halt = !halt;
      ready    = ($urandom_range(0, 3) != 0);
    end
    cyc(); rst = 1'b0; flush = 1'b0; halt = 1'b0; ready = 1'b1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
